// File: rtl/ps2_tx.sv
`default_nettype none
// ============================================================================
// Module   : ps2_tx
// Purpose  : Device-side PS/2 transmitter; buffers scan-code bytes in a FIFO
//            and serialises each as an 11-bit frame with a generated clock.
// Revision : 1.0
// ============================================================================
module ps2_tx #(
  parameter int CLK_DIV    = 8,
  parameter int GAP_CYCLES = 16,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [7:0]          in_data,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                inhibit,
  output logic                ps2_clk,
  output logic                ps2_data,
  output logic                busy,
  output logic                frame_done,
  output logic [ADDR_WIDTH:0] count
);

  localparam int c_depth   = 1 << ADDR_WIDTH;
  localparam int c_cnt_max = (CLK_DIV > GAP_CYCLES) ? CLK_DIV : GAP_CYCLES;
  localparam int c_cnt_w   = $clog2(c_cnt_max + 1);

  localparam logic [c_cnt_w-1:0]    c_half_last = c_cnt_w'(CLK_DIV - 1);
  localparam logic [c_cnt_w-1:0]    c_gap_last  = c_cnt_w'(GAP_CYCLES - 1);
  localparam logic [c_cnt_w-1:0]    c_cnt_one   = c_cnt_w'(1);
  localparam logic [3:0]            c_stop_idx  = 4'd10;
  localparam logic [ADDR_WIDTH-1:0] c_ptr_one   = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH:0]   c_occ_one   = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH:0]   c_occ_full  = (ADDR_WIDTH+1)'(c_depth);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HIGH = 2'd1,
    S_LOW  = 2'd2,
    S_GAP  = 2'd3
  } state_t;

  // ---------------------------------------------------------------- FIFO
  logic [7:0]            mem_q [c_depth];
  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic                  w_push;
  logic                  w_pop;
  logic [7:0]            w_head;

  assign in_ready = (count_q != c_occ_full);
  assign w_push   = in_valid && in_ready;
  assign w_head   = mem_q[rd_ptr_q];
  assign count    = count_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (w_push) wr_ptr_d = wr_ptr_q + c_ptr_one;
    if (w_pop)  rd_ptr_d = rd_ptr_q + c_ptr_one;
    case ({w_push, w_pop})
      2'b10:   count_d = count_q + c_occ_one;
      2'b01:   count_d = count_q - c_occ_one;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_push) mem_q[wr_ptr_q] <= in_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // ---------------------------------------------------------- serialiser
  state_t             state_q;
  logic [c_cnt_w-1:0] div_q;
  logic [3:0]         bit_q;
  logic               ps2_clk_q;
  logic               ps2_data_q;
  logic               busy_q;
  logic               frame_done_q;

  logic [10:0] w_frame;
  logic [3:0]  w_next_idx;
  logic        w_start;
  logic        w_abort;

  // The head byte stays in the FIFO until the stop bit completes, so an
  // aborted frame can simply be restarted from the same entry.
  assign w_frame    = {1'b1, ~^w_head, w_head, 1'b0};
  assign w_next_idx = bit_q + 4'd1;
  assign w_start    = (count_q != '0) && !inhibit;
  assign w_abort    = inhibit && (bit_q != c_stop_idx);
  assign w_pop      = (state_q == S_LOW) && (div_q == c_half_last) &&
                      (bit_q == c_stop_idx);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      div_q        <= '0;
      bit_q        <= '0;
      ps2_clk_q    <= 1'b1;
      ps2_data_q   <= 1'b1;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      if ((state_q == S_HIGH || state_q == S_LOW) && w_abort) begin
        state_q    <= S_GAP;
        div_q      <= '0;
        bit_q      <= '0;
        ps2_clk_q  <= 1'b1;
        ps2_data_q <= 1'b1;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (w_start) begin
              state_q    <= S_HIGH;
              div_q      <= '0;
              bit_q      <= '0;
              ps2_data_q <= w_frame[0];
              busy_q     <= 1'b1;
            end
          end
          S_HIGH: begin
            if (div_q == c_half_last) begin
              state_q   <= S_LOW;
              div_q     <= '0;
              ps2_clk_q <= 1'b0;
            end else begin
              div_q <= div_q + c_cnt_one;
            end
          end
          S_LOW: begin
            if (div_q == c_half_last) begin
              div_q     <= '0;
              ps2_clk_q <= 1'b1;
              if (bit_q == c_stop_idx) begin
                state_q      <= S_GAP;
                bit_q        <= '0;
                ps2_data_q   <= 1'b1;
                frame_done_q <= 1'b1;
              end else begin
                state_q    <= S_HIGH;
                bit_q      <= w_next_idx;
                ps2_data_q <= w_frame[w_next_idx];
              end
            end else begin
              div_q <= div_q + c_cnt_one;
            end
          end
          S_GAP: begin
            if (div_q == c_gap_last) begin
              div_q <= '0;
              // Chain straight into a pending frame so back-to-back bytes are
              // separated by exactly GAP_CYCLES and busy never dips.
              if (w_start) begin
                state_q    <= S_HIGH;
                bit_q      <= '0;
                ps2_data_q <= w_frame[0];
              end else begin
                state_q <= S_IDLE;
                busy_q  <= 1'b0;
              end
            end else begin
              div_q <= div_q + c_cnt_one;
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign ps2_clk    = ps2_clk_q;
  assign ps2_data   = ps2_data_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;

endmodule
`default_nettype wire

// File: tb/tb_ps2_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_ps2_tx
// Purpose  : Scoreboard bench for ps2_tx; a PS/2 receiver-style monitor
//            decodes frames and compares them against queued bytes.
// Revision : 1.0
// ============================================================================
module tb_ps2_tx;

  localparam int CLK_DIV    = 4;
  localparam int GAP_CYCLES = 16;
  localparam int ADDR_WIDTH = 3;
  localparam int DEPTH      = 1 << ADDR_WIDTH;
  localparam int FRAME_CYC  = 22 * CLK_DIV;

  logic                clk = 1'b0;
  logic                rst = 1'b0;
  logic [7:0]          in_data = 8'h00;
  logic                in_valid = 1'b0;
  logic                inhibit = 1'b0;
  logic                in_ready;
  logic                ps2_clk;
  logic                ps2_data;
  logic                busy;
  logic                frame_done;
  logic [ADDR_WIDTH:0] count;

  ps2_tx #(
    .CLK_DIV   (CLK_DIV),
    .GAP_CYCLES(GAP_CYCLES),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .inhibit   (inhibit),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .busy      (busy),
    .frame_done(frame_done),
    .count     (count)
  );

  always #5 clk = ~clk;

  int         n_checks = 0;
  int         n_err    = 0;
  int         cyc      = 0;
  logic [7:0] exp_q[$];
  int         mon_nb    = 0;
  int         mon_dones = 0;
  bit         tight_gap = 1'b0;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference frame: start, LSB-first data, odd parity, stop (bit 0 first on the wire).
  function automatic logic [10:0] model_frame(input logic [7:0] b);
    logic par;
    par = ($countones(b) % 2) == 0;
    return {1'b1, par, b, 1'b0};
  endfunction

  // ------------------------------------------------------------- monitor
  initial begin : monitor
    logic        prev_clk, prev_data, prev_fd;
    logic [10:0] rx;
    logic [7:0]  expb;
    int          high_run, start_cyc, pend_cyc, last_done_cyc;
    bit          done_pending, has_done;
    prev_clk = 1'b1; prev_data = 1'b1; prev_fd = 1'b0; rx = '0;
    high_run = 0; start_cyc = 0; pend_cyc = 0; last_done_cyc = 0;
    done_pending = 1'b0; has_done = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        mon_nb = 0; done_pending = 1'b0; has_done = 1'b0;
        prev_clk = 1'b1; prev_data = 1'b1; prev_fd = 1'b0; high_run = 0;
      end else begin
        if (ps2_clk && prev_data && !ps2_data && mon_nb == 0) begin
          start_cyc = cyc;
          if (tight_gap) chk("b2b_gap", cyc - last_done_cyc, GAP_CYCLES);
          else if (has_done) chk("gap_min", int'(cyc - last_done_cyc >= GAP_CYCLES), 1);
        end
        if (!prev_clk && !ps2_clk) chk("data_stable_low", ps2_data, prev_data);
        if (prev_clk && !ps2_clk) begin
          chk("data_hold_at_fall", ps2_data, prev_data);
          rx[mon_nb] = ps2_data;
          mon_nb++;
          if (mon_nb == 1) chk("first_fall_delay", cyc - start_cyc, CLK_DIV);
          if (mon_nb == 11) begin
            chk("frame_expected", int'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) begin
              expb = exp_q.pop_front();
              chk($sformatf("frame_bits_%02h", expb), int'(rx), int'(model_frame(expb)));
            end
            done_pending = 1'b1;
            pend_cyc     = cyc;
            mon_nb       = 0;
          end
        end
        high_run = ps2_clk ? high_run + 1 : 0;
        if (high_run > CLK_DIV && mon_nb > 0) mon_nb = 0;
        if (frame_done) begin
          chk("done_after_frame", int'(done_pending), 1);
          chk("done_width", int'(prev_fd), 0);
          chk("done_delay", cyc - pend_cyc, CLK_DIV);
          chk("frame_length", cyc - start_cyc, FRAME_CYC);
          done_pending  = 1'b0;
          has_done      = 1'b1;
          last_done_cyc = cyc;
          mon_dones++;
        end
        prev_clk  = ps2_clk;
        prev_data = ps2_data;
        prev_fd   = frame_done;
      end
    end
  end

  // ------------------------------------------------------------ stimulus
  task automatic push(input logic [7:0] b, input bit accept);
    @(negedge clk);
    in_data  = b;
    in_valid = 1'b1;
    if (accept) exp_q.push_back(b);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_dones(input int target, input int budget, input string name);
    for (int i = 0; i < budget && mon_dones < target; i++) @(negedge clk);
    chk(name, int'(mon_dones >= target), 1);
  endtask

  task automatic wait_idle(input int budget);
    for (int i = 0; i < budget && (busy || count != 0); i++) @(negedge clk);
    chk("reach_idle", int'(!busy && count == 0), 1);
  endtask

  task automatic wait_falls(input int n, input int budget);
    for (int i = 0; i < budget && mon_nb < n; i++) @(negedge clk);
    chk("reach_fall", int'(mon_nb >= n), 1);
    for (int i = 0; i < budget && !ps2_clk; i++) @(negedge clk);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
    $fatal(1, "timeout");
  end

  initial begin : stim
    logic [7:0] parity_vals [4];
    logic [7:0] b;
    int         base, drops, n;
    parity_vals[0] = 8'h00; parity_vals[1] = 8'hFF;
    parity_vals[2] = 8'hF0; parity_vals[3] = 8'h01;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_ps2_clk", ps2_clk, 1);
    chk("rst_ps2_data", ps2_data, 1);
    chk("rst_busy", busy, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_count", count, 0);
    chk("rst_in_ready", in_ready, 1);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // Single 0x1C: 2-cycle latency to start-bit drive
    push(8'h1C, 1'b1);
    chk("count_after_push", count, 1);
    chk("data_before_start", ps2_data, 1);
    @(posedge clk); #1;
    chk("start_drive", ps2_data, 0);
    chk("start_clk_high", ps2_clk, 1);
    chk("start_busy", busy, 1);
    wait_dones(1, 200, "single_done");
    chk("count_after_frame", count, 0);
    wait_idle(100);

    // Parity corners
    base = mon_dones;
    for (int i = 0; i < 4; i++) push(parity_vals[i], 1'b1);
    wait_dones(base + 4, 600, "parity_done");
    wait_idle(100);

    // Back-to-back frames
    base = mon_dones;
    push(8'hF0, 1'b1);
    push(8'h1C, 1'b1);
    @(negedge clk); #1;
    tight_gap = 1'b1;
    drops = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (mon_dones >= base + 2) break;
      if (!busy) drops++;
    end
    tight_gap = 1'b0;
    chk("b2b_done", int'(mon_dones >= base + 2), 1);
    chk("b2b_busy_drops", drops, 0);
    wait_idle(100);

    // Fill under inhibit, overflow push dropped
    @(negedge clk);
    inhibit = 1'b1;
    base = mon_dones;
    for (int i = 0; i < DEPTH; i++) push(8'($urandom), 1'b1);
    chk("fill_count", count, DEPTH);
    chk("fill_in_ready", in_ready, 0);
    push(8'hEE, 1'b0);
    chk("overflow_count", count, DEPTH);
    repeat (5) @(negedge clk);
    chk("inhibit_idle_busy", busy, 0);
    inhibit = 1'b0;
    wait_dones(base + DEPTH, DEPTH * (FRAME_CYC + GAP_CYCLES + 4) + 100, "fill_drain");
    wait_idle(100);

    // Abort during d3 of 0x5A, then retransmit
    base = mon_dones;
    push(8'h5A, 1'b1);
    wait_falls(4, 200);
    inhibit = 1'b1;
    @(posedge clk); #1;
    chk("abort_clk_high", ps2_clk, 1);
    chk("abort_data_high", ps2_data, 1);
    chk("abort_count", count, 1);
    chk("abort_busy", busy, 1);
    repeat (30) @(negedge clk);
    chk("abort_no_done", mon_dones, base);
    chk("abort_count_held", count, 1);
    inhibit = 1'b0;
    wait_dones(base + 1, 300, "retransmit_done");
    wait_idle(100);

    // Inhibit during stop bit does not abort
    base = mon_dones;
    b = 8'($urandom);
    push(b, 1'b1);
    wait_falls(10, 300);
    inhibit = 1'b1;
    wait_dones(base + 1, 50, "stop_inhibit_done");
    chk("stop_inhibit_count", count, 0);
    repeat (5) @(negedge clk);
    inhibit = 1'b0;
    wait_idle(100);

    // Reset mid-frame
    base = mon_dones;
    push(8'($urandom), 1'b1);
    wait_falls(5, 200);
    @(negedge clk); #2;
    rst = 1'b0;
    #1;
    chk("midrst_clk", ps2_clk, 1);
    chk("midrst_data", ps2_data, 1);
    chk("midrst_count", count, 0);
    chk("midrst_busy", busy, 0);
    exp_q.delete();
    repeat (3) @(negedge clk);
    chk("midrst_no_done", frame_done, 0);
    rst = 1'b1;
    repeat (30) @(negedge clk);
    chk("midrst_no_resume", mon_dones, base);
    push(8'h1C, 1'b1);
    wait_dones(base + 1, 200, "post_rst_done");
    wait_idle(100);

    // Randomised bursts with random inhibit pulses
    for (int r = 0; r < 6; r++) begin
      base = mon_dones;
      n = int'($urandom_range(1, 6));
      for (int i = 0; i < n; i++) begin
        repeat ($urandom_range(0, 3)) @(negedge clk);
        push(8'($urandom), 1'b1);
      end
      if (r % 2 == 1) begin
        repeat ($urandom_range(0, 150)) @(negedge clk);
        inhibit = 1'b1;
        repeat ($urandom_range(1, 8)) @(negedge clk);
        inhibit = 1'b0;
      end
      wait_dones(base + n, 2000, "random_done");
      wait_idle(200);
    end

    chk("queue_drained", exp_q.size(), 0);
    chk("final_count", count, 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
`default_nettype wire
